// File: rtl/pipe_stage_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_pkg
// Shared types and constants for the inter-stage pipeline register.
//   type_pipe_mode_e       : build-time mode selector (bypass / register / skid)
//   INSTR_NOP              : canonical NOP (addi x0, x0, 0), the default bubble
//   type_pipe_stage_perf_s : performance counter bundle for a stage boundary
// -----------------------------------------------------------------------------
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        PIPE_BYPASS = 2'd0,
        PIPE_REG    = 2'd1,
        PIPE_SKID   = 2'd2
    } type_pipe_mode_e;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    localparam int PERF_CNT_W = 16;

    typedef struct packed {
        logic [PERF_CNT_W-1:0] stall_cnt;
        logic [PERF_CNT_W-1:0] flush_cnt;
    } type_pipe_stage_perf_s;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Event counter that sticks at all-ones instead of wrapping.
//   clk   : clock
//   rst_n : synchronous active-low reset, clears the count
//   inc   : count one event this cycle
//   q     : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != {W{1'b1}})) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign q = cnt_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Reusable pipeline boundary register with valid/ready handshake, external
// stall and flush (flush inserts a bubble), and saturating perf counters.
// MODE: 0 = combinational bypass, 1 = single register, 2 = two-entry skid.
//   clk, rst_n           : clock, synchronous active-low reset
//   flush_i / stall_i    : squash / freeze the stage
//   up_valid_i/up_ready_o: upstream handshake, up_data_i / up_ctrl_i payload
//   dn_valid_o/dn_ready_i: downstream handshake, dn_data_o / dn_ctrl_o payload
//   flushed_o            : presented item is a flush bubble
//   stall_cnt_o          : cycles holding a valid item that did not issue
//   flush_cnt_o          : cycles with flush_i asserted
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                CTRL_W     = 8,
    parameter int                MODE       = 1,
    parameter logic [DATA_W-1:0] FLUSH_DATA = DATA_W'(INSTR_NOP),
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [DATA_W-1:0] up_data_i,
    input  logic [CTRL_W-1:0] up_ctrl_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [DATA_W-1:0] dn_data_o,
    output logic [CTRL_W-1:0] dn_ctrl_o,
    output logic              flushed_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    generate
        if (MODE == int'(PIPE_BYPASS)) begin : g_bypass
            // Pure wires; flush only rewrites the payload, validity passes through.
            assign up_ready_o = dn_ready_i & ~stall_i;
            assign dn_valid_o = up_valid_i;
            assign dn_data_o  = flush_i ? FLUSH_DATA : up_data_i;
            assign dn_ctrl_o  = flush_i ? '0 : up_ctrl_i;
            assign flushed_o  = flush_i;
        end else if (MODE == int'(PIPE_REG)) begin : g_reg
            logic              valid_reg;
            logic [DATA_W-1:0] data_reg;
            logic [CTRL_W-1:0] ctrl_reg;
            logic              flushed_reg;
            logic              accept;
            logic              issue;

            // During flush the stage swallows whatever upstream offers.
            assign up_ready_o = flush_i | (~stall_i & (~valid_reg | dn_ready_i));
            assign accept     = up_valid_i & up_ready_o;
            assign issue      = valid_reg & dn_ready_i & ~stall_i;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_reg   <= 1'b0;
                    data_reg    <= FLUSH_DATA;
                    ctrl_reg    <= '0;
                    flushed_reg <= 1'b0;
                end else if (flush_i) begin
                    valid_reg   <= 1'b1;
                    data_reg    <= FLUSH_DATA;
                    ctrl_reg    <= '0;
                    flushed_reg <= 1'b1;
                end else if (accept) begin
                    valid_reg   <= 1'b1;
                    data_reg    <= up_data_i;
                    ctrl_reg    <= up_ctrl_i;
                    flushed_reg <= 1'b0;
                end else if (issue) begin
                    valid_reg   <= 1'b0;
                end
            end

            assign dn_valid_o = valid_reg;
            assign dn_data_o  = data_reg;
            assign dn_ctrl_o  = ctrl_reg;
            assign flushed_o  = flushed_reg;
        end else begin : g_skid
            logic              main_valid_reg;
            logic [DATA_W-1:0] main_data_reg;
            logic [CTRL_W-1:0] main_ctrl_reg;
            logic              main_flushed_reg;
            logic              skid_valid_reg;
            logic [DATA_W-1:0] skid_data_reg;
            logic [CTRL_W-1:0] skid_ctrl_reg;
            logic              accept;
            logic              issue;

            // Ready comes from a flop (skid occupancy), never from dn_ready_i,
            // so long ready chains are cut here. Stall still freezes intake.
            assign up_ready_o = flush_i | (~stall_i & ~skid_valid_reg);
            assign accept     = up_valid_i & up_ready_o;
            assign issue      = main_valid_reg & dn_ready_i & ~stall_i;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    main_valid_reg   <= 1'b0;
                    main_data_reg    <= FLUSH_DATA;
                    main_ctrl_reg    <= '0;
                    main_flushed_reg <= 1'b0;
                    skid_valid_reg   <= 1'b0;
                    skid_data_reg    <= FLUSH_DATA;
                    skid_ctrl_reg    <= '0;
                end else if (flush_i) begin
                    main_valid_reg   <= 1'b1;
                    main_data_reg    <= FLUSH_DATA;
                    main_ctrl_reg    <= '0;
                    main_flushed_reg <= 1'b1;
                    skid_valid_reg   <= 1'b0;
                end else if (issue) begin
                    if (skid_valid_reg) begin
                        // Skid only ever holds real items: flush empties it.
                        main_data_reg    <= skid_data_reg;
                        main_ctrl_reg    <= skid_ctrl_reg;
                        main_flushed_reg <= 1'b0;
                        skid_valid_reg   <= 1'b0;
                    end else if (accept) begin
                        main_data_reg    <= up_data_i;
                        main_ctrl_reg    <= up_ctrl_i;
                        main_flushed_reg <= 1'b0;
                    end else begin
                        main_valid_reg   <= 1'b0;
                    end
                end else if (accept) begin
                    if (main_valid_reg) begin
                        skid_valid_reg   <= 1'b1;
                        skid_data_reg    <= up_data_i;
                        skid_ctrl_reg    <= up_ctrl_i;
                    end else begin
                        main_valid_reg   <= 1'b1;
                        main_data_reg    <= up_data_i;
                        main_ctrl_reg    <= up_ctrl_i;
                        main_flushed_reg <= 1'b0;
                    end
                end
            end

            assign dn_valid_o = main_valid_reg;
            assign dn_data_o  = main_data_reg;
            assign dn_ctrl_o  = main_ctrl_reg;
            assign flushed_o  = main_flushed_reg;
        end
    endgenerate

    // A stall cycle is any cycle a presented item fails to leave.
    logic stall_inc;
    assign stall_inc = dn_valid_o & (stall_i | ~dn_ready_i);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .q     (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_i),
        .q     (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Drives three instances (bypass, register, skid with 2-bit counters) from
// shared inputs. A queue-based model predicts every output each cycle; a
// directed prologue pins model and DUT to hand-computed values, followed by
// randomized traffic.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, stall, up_valid, dn_ready;
    logic [31:0] up_data;
    logic [7:0]  up_ctrl;

    logic        m0_up_ready, m0_dn_valid, m0_flushed;
    logic [31:0] m0_dn_data;
    logic [7:0]  m0_dn_ctrl;
    logic [15:0] m0_sc, m0_fc;
    logic        m1_up_ready, m1_dn_valid, m1_flushed;
    logic [31:0] m1_dn_data;
    logic [7:0]  m1_dn_ctrl;
    logic [15:0] m1_sc, m1_fc;
    logic        m2_up_ready, m2_dn_valid, m2_flushed;
    logic [31:0] m2_dn_data;
    logic [7:0]  m2_dn_ctrl;
    logic [1:0]  m2_sc, m2_fc;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .MODE(0), .CNT_W(16)) u_m0 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .stall_i(stall),
        .up_valid_i(up_valid), .up_ready_o(m0_up_ready), .up_data_i(up_data), .up_ctrl_i(up_ctrl),
        .dn_valid_o(m0_dn_valid), .dn_ready_i(dn_ready), .dn_data_o(m0_dn_data), .dn_ctrl_o(m0_dn_ctrl),
        .flushed_o(m0_flushed), .stall_cnt_o(m0_sc), .flush_cnt_o(m0_fc));

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .MODE(1), .CNT_W(16)) u_m1 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .stall_i(stall),
        .up_valid_i(up_valid), .up_ready_o(m1_up_ready), .up_data_i(up_data), .up_ctrl_i(up_ctrl),
        .dn_valid_o(m1_dn_valid), .dn_ready_i(dn_ready), .dn_data_o(m1_dn_data), .dn_ctrl_o(m1_dn_ctrl),
        .flushed_o(m1_flushed), .stall_cnt_o(m1_sc), .flush_cnt_o(m1_fc));

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .MODE(2), .CNT_W(2)) u_m2 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .stall_i(stall),
        .up_valid_i(up_valid), .up_ready_o(m2_up_ready), .up_data_i(up_data), .up_ctrl_i(up_ctrl),
        .dn_valid_o(m2_dn_valid), .dn_ready_i(dn_ready), .dn_data_o(m2_dn_data), .dn_ctrl_o(m2_dn_ctrl),
        .flushed_o(m2_flushed), .stall_cnt_o(m2_sc), .flush_cnt_o(m2_fc));

    // ---------------------------------------------------------------- checking
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------- model
    // Each registered stage is a FIFO of capacity 1 or 2; bypass is stateless.
    typedef struct {
        logic [31:0] d;
        logic [7:0]  c;
        logic        f;
    } item_t;

    item_t       q1[$];
    item_t       q2[$];
    int unsigned sc0, fc0, sc1, fc1, sc2, fc2;
    bit          live = 1'b0;

    localparam int unsigned MAX16 = 65535;
    localparam int unsigned MAX2  = 3;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    function automatic bit rdy1();
        return flush || (!stall && (q1.size() == 0 || dn_ready));
    endfunction

    function automatic bit rdy2();
        return flush || (!stall && q2.size() < 2);
    endfunction

    always @(posedge clk) begin : model_step
        item_t it;
        item_t bub;
        bit    a1, i1, a2, i2;
        it.d  = up_data; it.c = up_ctrl; it.f = 1'b0;
        bub.d = NOP;     bub.c = 8'h00;  bub.f = 1'b1;
        if (!rst_n) begin
            q1.delete(); q2.delete();
            sc0 = 0; fc0 = 0; sc1 = 0; fc1 = 0; sc2 = 0; fc2 = 0;
            live = 1'b1;
        end else begin
            if (up_valid && (stall || !dn_ready))     sc0 = sat(sc0, MAX16);
            if (q1.size() > 0 && (stall || !dn_ready)) sc1 = sat(sc1, MAX16);
            if (q2.size() > 0 && (stall || !dn_ready)) sc2 = sat(sc2, MAX2);
            if (flush) begin
                fc0 = sat(fc0, MAX16); fc1 = sat(fc1, MAX16); fc2 = sat(fc2, MAX2);
                q1.delete(); q1.push_back(bub);
                q2.delete(); q2.push_back(bub);
            end else begin
                a1 = up_valid && rdy1();
                i1 = q1.size() > 0 && dn_ready && !stall;
                a2 = up_valid && rdy2();
                i2 = q2.size() > 0 && dn_ready && !stall;
                if (i1) void'(q1.pop_front());
                if (a1) q1.push_back(it);
                if (i2) void'(q2.pop_front());
                if (a2) q2.push_back(it);
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("m0_up_ready", m0_up_ready, dn_ready && !stall);
            chk("m0_dn_valid", m0_dn_valid, up_valid);
            chk("m0_dn_data",  m0_dn_data,  flush ? NOP : up_data);
            chk("m0_dn_ctrl",  m0_dn_ctrl,  flush ? 32'h0 : 32'(up_ctrl));
            chk("m0_flushed",  m0_flushed,  flush);
            chk("m0_stall_cnt", m0_sc, sc0);
            chk("m0_flush_cnt", m0_fc, fc0);

            chk("m1_up_ready", m1_up_ready, rdy1());
            chk("m1_dn_valid", m1_dn_valid, q1.size() > 0);
            if (q1.size() > 0) begin
                chk("m1_dn_data", m1_dn_data, q1[0].d);
                chk("m1_dn_ctrl", m1_dn_ctrl, q1[0].c);
                chk("m1_flushed", m1_flushed, q1[0].f);
            end
            chk("m1_stall_cnt", m1_sc, sc1);
            chk("m1_flush_cnt", m1_fc, fc1);

            chk("m2_up_ready", m2_up_ready, rdy2());
            chk("m2_dn_valid", m2_dn_valid, q2.size() > 0);
            if (q2.size() > 0) begin
                chk("m2_dn_data", m2_dn_data, q2[0].d);
                chk("m2_dn_ctrl", m2_dn_ctrl, q2[0].c);
                chk("m2_flushed", m2_flushed, q2[0].f);
            end
            chk("m2_stall_cnt", m2_sc, sc2);
            chk("m2_flush_cnt", m2_fc, fc2);
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; stall = 1'b0; up_valid = 1'b0; dn_ready = 1'b1;
        up_data = '0; up_ctrl = '0;
        tick(); tick();
        @(negedge clk);
        chk("rst_m1_dn_valid", m1_dn_valid, 0);
        chk("rst_m1_dn_data",  m1_dn_data,  32'h13);
        chk("rst_m1_dn_ctrl",  m1_dn_ctrl,  0);
        chk("rst_m1_flushed",  m1_flushed,  0);
        chk("rst_m1_cnts",     {m1_sc, m1_fc}, 0);
        chk("rst_m2_dn_valid", m2_dn_valid, 0);
        chk("rst_m2_up_ready", m2_up_ready, 1);
        rst_n = 1'b1;
        tick();

        // Back-to-back stream through the single register
        for (int k = 1; k <= 3; k++) begin
            up_valid = 1'b1; up_data = k; up_ctrl = 8'(k + 16);
            @(negedge clk);
            chk("stream_m1_up_ready", m1_up_ready, 1);
            if (k > 1) chk("stream_m1_dn_data", m1_dn_data, k - 1);
            tick();
        end
        up_valid = 1'b0;
        @(negedge clk);
        chk("stream_m1_last", m1_dn_data, 3);
        chk("stream_m1_valid", m1_dn_valid, 1);
        chk("model_stream_last", (q1.size() == 1) ? q1[0].d : 32'hdead, 3);
        tick();

        // Stall holds item 5 for three cycles
        up_valid = 1'b1; up_data = 32'd5; up_ctrl = 8'h05;
        tick();
        up_valid = 1'b0; stall = 1'b1;
        tick(); tick(); tick();
        @(negedge clk);
        chk("stall_m1_data", m1_dn_data, 5);
        chk("stall_m1_up_ready", m1_up_ready, 0);
        chk("stall_m1_cnt", m1_sc, 3);
        chk("stall_m2_cnt", m2_sc, 3);
        chk("model_stall_cnt", sc1, 3);
        stall = 1'b0;
        tick();

        // Skid buffer absorbs two items while downstream is blocked
        dn_ready = 1'b0; up_valid = 1'b1; up_data = 32'd7; up_ctrl = 8'h07;
        @(negedge clk);
        chk("skid_ready_0", m2_up_ready, 1);
        tick();
        up_data = 32'd8; up_ctrl = 8'h08;
        @(negedge clk);
        chk("skid_ready_1", m2_up_ready, 1);
        tick();
        up_valid = 1'b0;
        @(negedge clk);
        chk("skid_full_ready", m2_up_ready, 0);
        chk("skid_head_7", m2_dn_data, 7);
        chk("model_skid_depth", q2.size(), 2);
        dn_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("skid_head_8", m2_dn_data, 8);
        chk("skid_valid_8", m2_dn_valid, 1);
        tick();
        @(negedge clk);
        chk("skid_drained", m2_dn_valid, 0);

        // Flush beats stall and discards upstream item 9
        up_valid = 1'b1; up_data = 32'd9; up_ctrl = 8'h09; stall = 1'b1; flush = 1'b1;
        #1;
        chk("flush_m0_data", m0_dn_data, 32'h13);
        chk("flush_m0_flushed", m0_flushed, 1);
        tick();
        flush = 1'b0; stall = 1'b0; up_valid = 1'b0;
        @(negedge clk);
        chk("flush_m1_data", m1_dn_data, 32'h13);
        chk("flush_m1_ctrl", m1_dn_ctrl, 0);
        chk("flush_m1_flushed", m1_flushed, 1);
        chk("flush_m1_cnt", m1_fc, 1);
        chk("flush_m2_data", m2_dn_data, 32'h13);
        chk("flush_m2_flushed", m2_flushed, 1);
        chk("model_flush_bubble", (q2.size() == 1) ? 32'(q2[0].f) : 32'hdead, 1);
        tick();
        up_valid = 1'b1; up_data = 32'hA; up_ctrl = 8'h0A;
        tick();
        up_valid = 1'b0;
        @(negedge clk);
        chk("after_bubble_flushed", m1_flushed, 0);
        chk("after_bubble_data", m1_dn_data, 32'hA);

        // 2-bit stall counter saturates
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; up_valid = 1'b1; up_data = 32'h55; up_ctrl = 8'h55;
        tick();
        up_valid = 1'b0; stall = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        @(negedge clk);
        chk("sat_m2_stall_cnt", m2_sc, 3);
        chk("sat_m1_stall_cnt", m1_sc, 6);
        chk("model_sat", sc2, 3);

        // Reset while the skid buffer is full
        stall = 1'b0; dn_ready = 1'b0; up_valid = 1'b1; up_data = 32'h66; up_ctrl = 8'h66;
        tick();
        up_valid = 1'b0;
        @(negedge clk);
        chk("full_m2_ready", m2_up_ready, 0);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("rstfull_m2_valid", m2_dn_valid, 0);
        chk("rstfull_m2_ready", m2_up_ready, 1);
        chk("rstfull_m2_cnts", {m2_sc, m2_fc}, 0);
        rst_n = 1'b1; dn_ready = 1'b1;
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            dn_ready = ($urandom_range(0, 3) != 0);
            up_valid = ($urandom_range(0, 2) != 0);
            up_data  = $urandom;
            up_ctrl  = 8'($urandom);
            tick();
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
